// File: rtl/tinyalu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tinyalu_arbiter
//  Purpose  : Shares a single tinyalu datapath between N requesters using
//             round-robin arbitration. The winning request is forwarded over
//             the ALU start/done handshake. Its result comes back on a shared
//             tagged response bus. A stuck operation (no done within TIMEOUT
//             cycles) is aborted by pulsing the ALU reset and reporting a
//             timeout error.
//  Ports    :
//    clk, reset           clock and synchronous active-high reset
//    req_valid[N]         request i pending, held with operands until accepted
//    req_A/req_B[8N]      operands of requester i at [8i+7:8i]
//    req_op[3N]           opcode of requester i at [3i+2:3i]
//    req_ready[N]         one-hot accept (combinational)
//    rsp_valid            one-cycle response pulse
//    rsp_id               requester index of the response
//    rsp_result[16]       ALU result, 0 on error
//    rsp_err[2]           00 ok, 01 illegal opcode, 10 timeout
//    alu_A/B/op/start     registered drive of the tinyalu inputs
//    alu_reset_n          registered active-low reset of the tinyalu
//    alu_done/alu_result  tinyalu completion handshake
//  Option   : TINYALU_ARB_STATS_EN adds stat_ops (accepted requests) and
//             stat_timeouts (RECOVER entries), both saturating.
//  Revision : 1.0  initial release
// ============================================================================
module tinyalu_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req_valid,
  input  logic [8*N-1:0]       req_A,
  input  logic [8*N-1:0]       req_B,
  input  logic [3*N-1:0]       req_op,
  output logic [N-1:0]         req_ready,
  output logic                 rsp_valid,
  output logic [$clog2(N)-1:0] rsp_id,
  output logic [15:0]          rsp_result,
  output logic [1:0]           rsp_err,
  output logic [7:0]           alu_A,
  output logic [7:0]           alu_B,
  output logic [2:0]           alu_op,
  output logic                 alu_start,
  output logic                 alu_reset_n,
  input  logic                 alu_done,
  input  logic [15:0]          alu_result
`ifdef TINYALU_ARB_STATS_EN
  ,
  output logic [31:0]          stat_ops,
  output logic [15:0]          stat_timeouts
`endif
);

  localparam int IDW = $clog2(N);

  localparam logic [1:0] c_ERR_OK      = 2'b00;
  localparam logic [1:0] c_ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] c_ERR_TIMEOUT = 2'b10;
  localparam logic [7:0] c_CNT_LAST    = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RESP    = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Registered state and outputs
  // --------------------------------------------------------------------------
  state_t          r_state;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_id;
  logic [7:0]      r_cnt;
  logic            r_alu_start;
  logic            r_alu_reset_n;
  logic [7:0]      r_alu_a;
  logic [7:0]      r_alu_b;
  logic [2:0]      r_alu_op;
  logic            r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic [15:0]     r_rsp_result;
  logic [1:0]      r_rsp_err;

  // --------------------------------------------------------------------------
  // Combinational arbitration
  // --------------------------------------------------------------------------
  logic            w_found;
  logic [IDW-1:0]  w_win;
  logic [IDW-1:0]  w_cand;
  logic [N-1:0]    w_ready;
  logic            w_accept;
  logic [7:0]      w_a;
  logic [7:0]      w_b;
  logic [2:0]      w_op;
  logic            w_legal;
  logic            w_timeout_hit;

  // Walk the requesters starting just after the last grant. The candidate
  // index wraps explicitly at N-1 so non-power-of-two N works.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = r_ptr;
    for (int k = 0; k < N; k++) begin
      w_cand = (w_cand == IDW'(N - 1)) ? '0 : w_cand + 1'b1;
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  // Grants are only offered while idle and with the ALU out of reset.
  assign w_accept = (r_state == S_IDLE) && r_alu_reset_n && w_found;

  always_comb begin
    w_ready = '0;
    if (w_accept) begin
      w_ready[w_win] = 1'b1;
    end
  end

  // Operand/opcode mux for the current winner.
  always_comb begin
    w_a  = '0;
    w_b  = '0;
    w_op = '0;
    for (int i = 0; i < N; i++) begin
      if (w_win == IDW'(i)) begin
        w_a  = req_A[8*i +: 8];
        w_b  = req_B[8*i +: 8];
        w_op = req_op[3*i +: 3];
      end
    end
  end

  always_comb begin
    case (w_op)
      3'b001, 3'b010, 3'b011, 3'b100: w_legal = 1'b1;
      default:                        w_legal = 1'b0;
    endcase
  end

  // Done wins over timeout when both land in the same cycle.
  assign w_timeout_hit = (r_state == S_WAIT) && !alu_done && (r_cnt == c_CNT_LAST);

  // --------------------------------------------------------------------------
  // Main FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_ptr         <= IDW'(N - 1);
      r_id          <= '0;
      r_cnt         <= '0;
      r_alu_start   <= 1'b0;
      r_alu_reset_n <= 1'b0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_op      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= '0;
      r_rsp_result  <= '0;
      r_rsp_err     <= c_ERR_OK;
    end else begin
      // Response is a single-cycle pulse; ALU reset only drops in RECOVER.
      r_rsp_valid   <= 1'b0;
      r_alu_reset_n <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_id  <= w_win;
            r_ptr <= w_win;
            if (w_legal) begin
              r_alu_a     <= w_a;
              r_alu_b     <= w_b;
              r_alu_op    <= w_op;
              r_alu_start <= 1'b1;
              r_cnt       <= '0;
              r_state     <= S_WAIT;
            end else begin
              // Illegal opcode: the ALU is never touched.
              r_rsp_valid  <= 1'b1;
              r_rsp_id     <= w_win;
              r_rsp_result <= '0;
              r_rsp_err    <= c_ERR_ILLEGAL;
              r_state      <= S_RESP;
            end
          end
        end

        S_WAIT: begin
          if (alu_done) begin
            r_alu_start  <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_rsp_id     <= r_id;
            r_rsp_result <= alu_result;
            r_rsp_err    <= c_ERR_OK;
            r_state      <= S_RESP;
          end else if (w_timeout_hit) begin
            r_alu_start   <= 1'b0;
            r_alu_reset_n <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_id      <= r_id;
            r_rsp_result  <= '0;
            r_rsp_err     <= c_ERR_TIMEOUT;
            r_state       <= S_RECOVER;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        S_RESP: begin
          r_state <= S_IDLE;
        end

        S_RECOVER: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready   = w_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_result  = r_rsp_result;
  assign rsp_err     = r_rsp_err;
  assign alu_A       = r_alu_a;
  assign alu_B       = r_alu_b;
  assign alu_op      = r_alu_op;
  assign alu_start   = r_alu_start;
  assign alu_reset_n = r_alu_reset_n;

  // --------------------------------------------------------------------------
  // Optional statistics
  // --------------------------------------------------------------------------
`ifdef TINYALU_ARB_STATS_EN
  logic [31:0] r_stat_ops;
  logic [15:0] r_stat_timeouts;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_ops      <= '0;
      r_stat_timeouts <= '0;
    end else begin
      if (w_accept && (r_stat_ops != '1)) begin
        r_stat_ops <= r_stat_ops + 32'd1;
      end
      if (w_timeout_hit && (r_stat_timeouts != '1)) begin
        r_stat_timeouts <= r_stat_timeouts + 16'd1;
      end
    end
  end

  assign stat_ops      = r_stat_ops;
  assign stat_timeouts = r_stat_timeouts;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tinyalu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tinyalu_arbiter
//  Purpose  : Directed self-checking bench for tinyalu_arbiter with a small
//             behavioural tinyalu model (programmable done delay).
//  Revision : 1.0  initial release
// ============================================================================
module tb_tinyalu_arbiter;

  localparam int N       = 4;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [8*N-1:0]   req_A;
  logic [8*N-1:0]   req_B;
  logic [3*N-1:0]   req_op;
  logic [N-1:0]     req_ready;
  logic             rsp_valid;
  logic [1:0]       rsp_id;
  logic [15:0]      rsp_result;
  logic [1:0]       rsp_err;
  logic [7:0]       alu_A;
  logic [7:0]       alu_B;
  logic [2:0]       alu_op;
  logic             alu_start;
  logic             alu_reset_n;
  logic             alu_done;
  logic [15:0]      alu_result;
`ifdef TINYALU_ARB_STATS_EN
  logic [31:0]      stat_ops;
  logic [15:0]      stat_timeouts;
`endif

  always #5 clk = ~clk;

  tinyalu_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_A       (req_A),
    .req_B       (req_B),
    .req_op      (req_op),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_result  (rsp_result),
    .rsp_err     (rsp_err),
    .alu_A       (alu_A),
    .alu_B       (alu_B),
    .alu_op      (alu_op),
    .alu_start   (alu_start),
    .alu_reset_n (alu_reset_n),
    .alu_done    (alu_done),
    .alu_result  (alu_result)
`ifdef TINYALU_ARB_STATS_EN
    ,
    .stat_ops      (stat_ops),
    .stat_timeouts (stat_timeouts)
`endif
  );

  // --------------------------------------------------------------------------
  // tinyalu model: done rises dly cycles after start first goes high.
  // --------------------------------------------------------------------------
  int   sc;
  int   dly;
  logic done_en;

  always @(posedge clk) begin
    if (!alu_start) sc <= 0;
    else            sc <= sc + 1;
  end

  assign alu_done = done_en && alu_start && (sc == dly);

  always_comb begin
    alu_result = 16'h0000;
    case (alu_op)
      3'b001: alu_result = {8'h00, alu_A} + {8'h00, alu_B};
      3'b010: alu_result = {8'h00, alu_A & alu_B};
      3'b011: alu_result = {8'h00, alu_A ^ alu_B};
      3'b100: alu_result = alu_A * alu_B;
      default: alu_result = 16'h0000;
    endcase
  end

  // --------------------------------------------------------------------------
  // Checking helpers
  // --------------------------------------------------------------------------
  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op);
    req_A[i*8 +: 8] = a;
    req_B[i*8 +: 8] = b;
    req_op[i*3 +: 3] = op;
  endtask

  // Advance until rsp_valid is seen, counting cycles with alu_start high.
  task automatic wait_rsp(input int budget, output int starts, output bit seen);
    starts = 0;
    seen   = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      if (rsp_valid) begin
        seen = 1'b1;
      end else begin
        if (alu_start) starts++;
        tick();
      end
    end
  endtask

  int         starts;
  bit         seen;
  int         gr   [5];
  logic [1:0] rids [5];
  logic [15:0] rres[5];
  int         exp_gr [5]   = '{0, 1, 2, 3, 0};
  logic [15:0] exp_x [4]   = '{16'h00FF, 16'h00A5, 16'h0099, 16'h00FE};

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int ngr, nrsp, multi;

    reset     = 1'b1;
    req_valid = '0;
    req_A     = '0;
    req_B     = '0;
    req_op    = '0;
    done_en   = 1'b1;
    dly       = 1;
    tick();
    tick();

    // ---------------- reset state ----------------
    req_valid = 4'b0001;
    #1;
    check("rst_ready",      {28'd0, req_ready}, 32'h0);
    check("rst_rsp_valid",  {31'd0, rsp_valid}, 32'h0);
    check("rst_rsp_id",     {30'd0, rsp_id}, 32'h0);
    check("rst_rsp_result", {16'd0, rsp_result}, 32'h0);
    check("rst_rsp_err",    {30'd0, rsp_err}, 32'h0);
    check("rst_alu_start",  {31'd0, alu_start}, 32'h0);
    check("rst_alu_reset_n",{31'd0, alu_reset_n}, 32'h0);
    check("rst_alu_A",      {24'd0, alu_A}, 32'h0);
    check("rst_alu_op",     {29'd0, alu_op}, 32'h0);
    req_valid = '0;
    reset     = 1'b0;
    tick();
    check("rstn_rise", {31'd0, alu_reset_n}, 32'h1);

    // ---------------- single add, requester 0 ----------------
    set_req(0, 8'h12, 8'h34, 3'b001);
    req_valid = 4'b0001;
    #1;
    check("add_ready", {28'd0, req_ready}, 32'h1);
    tick();
    req_valid = '0;
    check("add_start",  {31'd0, alu_start}, 32'h1);
    check("add_alu_A",  {24'd0, alu_A}, 32'h12);
    check("add_alu_B",  {24'd0, alu_B}, 32'h34);
    check("add_alu_op", {29'd0, alu_op}, 32'h1);
    check("add_ready_wait", {28'd0, req_ready}, 32'h0);
    wait_rsp(10, starts, seen);
    check("add_seen",   {31'd0, seen}, 32'h1);
    check("add_starts", starts, 32'd2);
    check("add_id",     {30'd0, rsp_id}, 32'h0);
    check("add_result", {16'd0, rsp_result}, 32'h0046);
    check("add_err",    {30'd0, rsp_err}, 32'h0);
    check("add_start_low_resp", {31'd0, alu_start}, 32'h0);
    tick();
    check("add_pulse_end", {31'd0, rsp_valid}, 32'h0);
    check("add_hold",      {16'd0, rsp_result}, 32'h0046);

    // ---------------- mul, requester 1, done after 3 ----------------
    dly = 3;
    set_req(1, 8'hFF, 8'hFF, 3'b100);
    req_valid = 4'b0010;
    #1;
    check("mul_ready", {28'd0, req_ready}, 32'h2);
    tick();
    req_valid = '0;
    wait_rsp(20, starts, seen);
    check("mul_seen",   {31'd0, seen}, 32'h1);
    check("mul_starts", starts, 32'd4);
    check("mul_id",     {30'd0, rsp_id}, 32'h1);
    check("mul_result", {16'd0, rsp_result}, 32'hFE01);
    check("mul_err",    {30'd0, rsp_err}, 32'h0);
    tick();

    // ---------------- illegal op, requester 2 ----------------
    set_req(2, 8'h55, 8'h66, 3'b110);
    req_valid = 4'b0100;
    #1;
    check("ill_ready", {28'd0, req_ready}, 32'h4);
    tick();
    req_valid = '0;
    check("ill_valid",  {31'd0, rsp_valid}, 32'h1);
    check("ill_id",     {30'd0, rsp_id}, 32'h2);
    check("ill_err",    {30'd0, rsp_err}, 32'h1);
    check("ill_result", {16'd0, rsp_result}, 32'h0);
    check("ill_no_start", {31'd0, alu_start}, 32'h0);
    check("ill_alu_op_kept", {29'd0, alu_op}, 32'h4);
    tick();
    check("ill_pulse_end", {31'd0, rsp_valid}, 32'h0);

    // ---------------- timeout, requester 3 ----------------
    done_en = 1'b0;
    set_req(3, 8'h01, 8'h02, 3'b001);
    req_valid = 4'b1000;
    #1;
    check("to_ready", {28'd0, req_ready}, 32'h8);
    tick();
    req_valid = '0;
    wait_rsp(40, starts, seen);
    check("to_seen",    {31'd0, seen}, 32'h1);
    check("to_starts",  starts, 32'd16);
    check("to_reset_n", {31'd0, alu_reset_n}, 32'h0);
    check("to_err",     {30'd0, rsp_err}, 32'h2);
    check("to_result",  {16'd0, rsp_result}, 32'h0);
    check("to_id",      {30'd0, rsp_id}, 32'h3);
    tick();
    check("to_pulse_end", {31'd0, rsp_valid}, 32'h0);
    check("to_reset_n_up", {31'd0, alu_reset_n}, 32'h1);
    check("to_start_low", {31'd0, alu_start}, 32'h0);

    // ---------------- normal op after recovery ----------------
    done_en = 1'b1;
    dly     = 1;
    set_req(0, 8'h05, 8'h07, 3'b001);
    req_valid = 4'b0001;
    #1;
    check("rec_ready", {28'd0, req_ready}, 32'h1);
    tick();
    req_valid = '0;
    wait_rsp(10, starts, seen);
    check("rec_seen",   {31'd0, seen}, 32'h1);
    check("rec_result", {16'd0, rsp_result}, 32'h000C);
    check("rec_err",    {30'd0, rsp_err}, 32'h0);
    check("rec_id",     {30'd0, rsp_id}, 32'h0);
    tick();

    // ---------------- reset in the middle of WAIT ----------------
    dly = 3;
    set_req(1, 8'h02, 8'h03, 3'b100);
    req_valid = 4'b0010;
    #1;
    check("mr_ready", {28'd0, req_ready}, 32'h2);
    tick();
    req_valid = '0;
    check("mr_start", {31'd0, alu_start}, 32'h1);
    tick();
    reset = 1'b1;
    tick();
    check("mr_start_low", {31'd0, alu_start}, 32'h0);
    check("mr_reset_n",   {31'd0, alu_reset_n}, 32'h0);
    check("mr_no_rsp",    {31'd0, rsp_valid}, 32'h0);
    reset = 1'b0;
    tick();
    check("mr_reset_n_up", {31'd0, alu_reset_n}, 32'h1);
    check("mr_no_rsp2",    {31'd0, rsp_valid}, 32'h0);

    // ---------------- round robin, all requesters valid ----------------
    dly = 1;
    set_req(0, 8'h0F, 8'hF0, 3'b011);
    set_req(1, 8'hAA, 8'h0F, 3'b011);
    set_req(2, 8'h81, 8'h18, 3'b011);
    set_req(3, 8'hFF, 8'h01, 3'b011);
    req_valid = 4'b1111;
    #1;
    ngr   = 0;
    nrsp  = 0;
    multi = 0;
    for (int c = 0; c < 60 && nrsp < 5; c++) begin
      if ($countones(req_ready) > 1) multi++;
      if (req_ready != '0 && ngr < 5) begin
        for (int b = 0; b < N; b++) if (req_ready[b]) gr[ngr] = b;
        ngr++;
      end
      if (rsp_valid && nrsp < 5) begin
        rids[nrsp] = rsp_id;
        rres[nrsp] = rsp_result;
        nrsp++;
      end
      tick();
    end
    req_valid = '0;
    check("rr_grants", ngr, 32'd5);
    check("rr_rsps",   nrsp, 32'd5);
    check("rr_onehot", multi, 32'd0);
    for (int k = 0; k < 5; k++) begin
      if (k < ngr)  check($sformatf("rr_grant%0d", k), gr[k], exp_gr[k]);
      if (k < nrsp) begin
        check($sformatf("rr_rsp_id%0d", k), {30'd0, rids[k]}, exp_gr[k]);
        check($sformatf("rr_rsp_res%0d", k), {16'd0, rres[k]},
              {16'd0, exp_x[exp_gr[k]]});
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
